// File: rtl/lsu_access_unit.sv
// Load/store unit between the EX/MEM pipeline register and the data RAM port.
// Handles one access at a time. It places store data and strobes into the RAM
// lane, and extracts and extends load data from the read lane. Illegal widths
// and misaligned addresses trap without touching RAM. A request that RAM never
// acknowledges is abandoned after TIMEOUT_CYC cycles and answered with a
// timeout error.
module lsu_access_unit #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYC    = 255,
  parameter int ALLOW_MISALIGN = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_type_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic [1:0]        resp_err_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [XLEN-1:0]   ram_addr_o,
  output logic [XLEN/8-1:0] ram_w_strb_o,
  output logic [XLEN-1:0]   ram_w_data_o,
  input  logic              ram_ack_i,
  input  logic [XLEN-1:0]   ram_r_data_i
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_MIS  = 2'd1;
  localparam logic [1:0] ERR_ILL  = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  // Elaboration-time guards on the parameter space.
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("lsu_access_unit: XLEN must be 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tout
    $error("lsu_access_unit: TIMEOUT_CYC must be >= 1");
  end
  if (ALLOW_MISALIGN != 0) begin : g_bad_mis
    $error("lsu_access_unit: ALLOW_MISALIGN is reserved and must be 0");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]      resp_err_q, resp_err_d;
  logic            ram_req_q, ram_req_d;
  logic            ram_we_q, ram_we_d;
  logic [XLEN-1:0] ram_addr_q, ram_addr_d;
  logic [NB-1:0]   ram_w_strb_q, ram_w_strb_d;
  logic [XLEN-1:0] ram_w_data_q, ram_w_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      type_q, type_d;
  logic [OFFW-1:0] off_q, off_d;

  // Request decode: legality, alignment and store lane placement.
  logic [1:0]      sz_log;
  logic [2:0]      amask;
  logic            ill, mis;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] wmask, w_lane;
  logic [NB-1:0]   smask, s_lane;

  // Decode the incoming access. The low two type bits encode log2(size) for both loads and stores.
  always_comb begin
    sz_log = req_type_i[1:0];
    off    = req_addr_i[OFFW-1:0];
    ill    = req_store_i ? req_type_i[2] : (req_type_i == 3'd7);
    if ((XLEN == 32) && ((req_type_i == 3'd3) || (!req_store_i && req_type_i == 3'd6)))
      ill = 1'b1;
    case (sz_log)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    mis    = |(req_addr_i[2:0] & amask);
    wmask  = {XLEN{1'b1}} >> (XLEN - (8 << sz_log));
    smask  = {NB{1'b1}} >> (NB - (1 << sz_log));
    w_lane = (req_wdata_i & wmask) << {off, 3'b000};
    s_lane = smask << off;
  end

  // Load extraction: shift the addressed bytes down, then extend from the access size.
  logic [XLEN-1:0] r_sh, r_top, ld_ext;
  int unsigned     pad;

  // Move the loaded field to the top of the word and shift it back down, arithmetically for signed types.
  always_comb begin
    r_sh  = ram_r_data_i >> {off_q, 3'b000};
    pad   = XLEN - (8 << type_q[1:0]);
    r_top = r_sh << pad;
    if (type_q[2]) ld_ext = r_top >> pad;
    else           ld_ext = $unsigned($signed(r_top) >>> pad);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_w_strb_q <= '0;
      ram_w_data_q <= '0;
      cnt_q        <= '0;
      type_q       <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_w_strb_q <= ram_w_strb_d;
      ram_w_data_q <= ram_w_data_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      off_q        <= off_d;
    end
  end

  // Next state and next registered outputs. Every register holds its value unless a transition updates it.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_w_strb_d = ram_w_strb_q;
    ram_w_data_d = ram_w_data_q;
    cnt_d        = cnt_q;
    type_d       = type_q;
    off_d        = off_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          if (ill || mis) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = ill ? ERR_ILL : ERR_MIS;
          end else begin
            state_d      = REQ;
            ram_req_d    = 1'b1;
            ram_we_d     = req_store_i;
            ram_addr_d   = {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
            ram_w_strb_d = req_store_i ? s_lane : '0;
            ram_w_data_d = req_store_i ? w_lane : '0;
            cnt_d        = '0;
            type_d       = req_type_i;
            off_d        = off;
          end
        end
      end
      REQ: begin
        // An ack in the limit cycle still wins over the timeout.
        if (ram_ack_i || ((cnt_q + 1'b1) == CW'(TIMEOUT_CYC))) begin
          state_d      = RESP;
          ram_req_d    = 1'b0;
          ram_we_d     = 1'b0;
          ram_w_strb_d = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = ram_ack_i ? ERR_OK : ERR_TOUT;
          resp_rdata_d = (ram_ack_i && !ram_we_q) ? ld_ext : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign ram_req_o    = ram_req_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_w_strb_o = ram_w_strb_q;
  assign ram_w_data_o = ram_w_data_q;
endmodule

// File: tb/tb_lsu_access_unit.sv
// Bench for lsu_access_unit. It instantiates a 64-bit unit with a short
// timeout and a 32-bit unit. Both units share the data-side inputs, and each
// has its own handshake lines. Expected values come from a directed table and
// from a byte-wise reference model.
module tb_lsu_access_unit;
  typedef struct packed {
    logic [1:0]  err;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    bit          is32;
    logic        st;
    logic [2:0]  ty;
    logic [63:0] addr, wdata, rdata;
    int          ack_dly, rdy_dly;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    logic        req_ready, resp_valid, ram_req, ram_we;
    logic [1:0]  err;
    logic [63:0] rdata, addr, wdata;
    logic [7:0]  strb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        st;
  logic [2:0]  ty;
  logic [63:0] addr, wdata, rdata;
  logic        rv [2];
  logic        rr [2];
  logic        ack [2];

  logic        a_rdy, a_rv, a_req, a_we;
  logic [1:0]  a_err;
  logic [63:0] a_rd, a_ad, a_wd;
  logic [7:0]  a_sb;
  logic        b_rdy, b_rv, b_req, b_we;
  logic [1:0]  b_err;
  logic [31:0] b_rd, b_ad, b_wd;
  logic [3:0]  b_sb;

  obs_t obs [2];
  int nvec = 0;
  int nmis = 0;
  vec_t vq [$];

  always #5 clk = ~clk;

  lsu_access_unit #(.XLEN(64), .TIMEOUT_CYC(4), .ALLOW_MISALIGN(0)) u64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[0]), .req_ready_o(a_rdy),
    .req_store_i(st), .req_type_i(ty), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(a_rv), .resp_ready_i(rr[0]), .resp_rdata_o(a_rd), .resp_err_o(a_err),
    .ram_req_o(a_req), .ram_we_o(a_we), .ram_addr_o(a_ad), .ram_w_strb_o(a_sb),
    .ram_w_data_o(a_wd), .ram_ack_i(ack[0]), .ram_r_data_i(rdata));

  lsu_access_unit #(.XLEN(32), .TIMEOUT_CYC(8), .ALLOW_MISALIGN(0)) u32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[1]), .req_ready_o(b_rdy),
    .req_store_i(st), .req_type_i(ty), .req_addr_i(addr[31:0]), .req_wdata_i(wdata[31:0]),
    .resp_valid_o(b_rv), .resp_ready_i(rr[1]), .resp_rdata_o(b_rd), .resp_err_o(b_err),
    .ram_req_o(b_req), .ram_we_o(b_we), .ram_addr_o(b_ad), .ram_w_strb_o(b_sb),
    .ram_w_data_o(b_wd), .ram_ack_i(ack[1]), .ram_r_data_i(rdata[31:0]));

  always_comb begin
    obs[0] = '{a_rdy, a_rv, a_req, a_we, a_err, a_rd, a_ad, a_wd, a_sb};
    obs[1] = '{b_rdy, b_rv, b_req, b_we, b_err, {32'b0, b_rd}, {32'b0, b_ad}, {32'b0, b_wd}, {4'b0, b_sb}};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: walks bytes of the access rather than shifting words.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int xb, size, o;
    logic [63:0] a, w, r, val;
    e  = '0;
    xb = v.is32 ? 4 : 8;
    a  = v.is32 ? {32'b0, v.addr[31:0]}  : v.addr;
    w  = v.is32 ? {32'b0, v.wdata[31:0]} : v.wdata;
    r  = v.is32 ? {32'b0, v.rdata[31:0]} : v.rdata;
    case (v.ty)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2, 3'd6: size = 4;
      default:    size = 8;
    endcase
    if ((v.st && v.ty > 3'd3) || (!v.st && v.ty == 3'd7) ||
        (v.is32 && size == 8) || (v.is32 && !v.st && v.ty == 3'd6)) begin
      e.err = 2'd2;
      return e;
    end
    if (a % size != 0) begin
      e.err = 2'd1;
      return e;
    end
    o      = int'(a % xb);
    e.addr = a - o;
    e.we   = v.st;
    if (v.st) begin
      for (int i = 0; i < size; i++) begin
        e.strb[o+i]           = 1'b1;
        e.wdata[8*(o+i) +: 8] = w[8*i +: 8];
      end
    end else begin
      val = '0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = r[8*(o+i) +: 8];
      if (v.ty < 3'd4 && val[8*size-1])
        for (int b = 8*size; b < 8*xb; b++) val[b] = 1'b1;
      e.rdata = val;
    end
    return e;
  endfunction

  task automatic add(input bit is32, input logic s, input logic [2:0] t, input logic [63:0] a,
                     input logic [63:0] w, input logic [63:0] r, input int ad, input int rd,
                     input logic [1:0] err, input logic [63:0] ea, input logic [7:0] es,
                     input logic [63:0] ew, input logic [63:0] er);
    vec_t v;
    v.is32 = is32; v.st = s; v.ty = t; v.addr = a; v.wdata = w; v.rdata = r;
    v.ack_dly = ad; v.rdy_dly = rd;
    v.e = '{err, s, ea, es, ew, er};
    vq.push_back(v);
  endtask

  // One full access: accept, RAM phase (or trap), held response, consume.
  task automatic do_access(input vec_t v, input exp_t e);
    int s;
    s = v.is32 ? 1 : 0;
    chk("idle req_ready", obs[s].req_ready, 1);
    st = v.st; ty = v.ty; addr = v.addr; wdata = v.wdata; rdata = v.rdata;
    rv[s] = 1'b1;
    @(posedge clk); #1;
    rv[s] = 1'b0;
    chk("req_ready after accept", obs[s].req_ready, 0);
    if (e.err != 2'd0) begin
      chk("trap resp_valid", obs[s].resp_valid, 1);
      chk("trap ram_req", obs[s].ram_req, 0);
    end else begin
      chk("ram_req", obs[s].ram_req, 1);
      chk("ram_addr", obs[s].addr, e.addr);
      chk("ram_we", obs[s].ram_we, e.we);
      chk("ram_w_strb", obs[s].strb, e.strb);
      chk("ram_w_data", obs[s].wdata, e.wdata);
      chk("resp_valid in req", obs[s].resp_valid, 0);
      for (int i = 0; i < v.ack_dly; i++) begin
        @(posedge clk); #1;
        chk("ram_req held", obs[s].ram_req, 1);
        chk("ram_addr held", obs[s].addr, e.addr);
        chk("ram_w_data held", obs[s].wdata, e.wdata);
      end
      ack[s] = 1'b1;
      @(posedge clk); #1;
      ack[s] = 1'b0;
      chk("ram_req drop", obs[s].ram_req, 0);
      chk("resp_valid", obs[s].resp_valid, 1);
    end
    chk("resp_err", obs[s].err, e.err);
    chk("resp_rdata", obs[s].rdata, e.rdata);
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(posedge clk); #1;
      chk("bp resp_valid", obs[s].resp_valid, 1);
      chk("bp resp_err", obs[s].err, e.err);
      chk("bp resp_rdata", obs[s].rdata, e.rdata);
      chk("bp req_ready", obs[s].req_ready, 0);
    end
    rr[s] = 1'b1;
    @(posedge clk); #1;
    rr[s] = 1'b0;
    chk("resp done valid", obs[s].resp_valid, 0);
    chk("resp done ready", obs[s].req_ready, 1);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 2; i++) begin rv[i] = 0; rr[i] = 0; ack[i] = 0; end
    st = 0; ty = 0; addr = 0; wdata = 0; rdata = 0;

    // Directed table: {is32, st, ty, addr, wdata, rdata, ack_dly, rdy_dly, err, ram_addr, strb, wdata, rdata}
    add(0, 1, 0, 64'h8000_0005, 64'hAB, 0, 2, 0, 0, 64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000, 0);
    add(0, 0, 1, 64'h1006, 0, 64'h8001_0000_0000_0000, 0, 0, 0, 64'h1000, 0, 0, 64'hFFFF_FFFF_FFFF_8001);
    add(0, 0, 5, 64'h1006, 0, 64'h8001_0000_0000_0000, 1, 5, 0, 64'h1000, 0, 0, 64'h8001);
    add(0, 0, 2, 64'h1002, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 7, 64'h1000, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 4, 64'h1000, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 0, 7, 64'h1001, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 3, 64'h1004, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 3, 64'h10, 64'h0123_4567_89AB_CDEF, 0, 3, 5, 0, 64'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
    add(0, 0, 0, 64'h3, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
    add(0, 0, 4, 64'h3, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h80);
    add(0, 0, 2, 64'h2004, 0, 64'h8765_4321_0000_0000, 2, 0, 0, 64'h2000, 0, 0, 64'hFFFF_FFFF_8765_4321);
    add(0, 0, 6, 64'h2004, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 64'h2000, 0, 0, 64'h8765_4321);
    add(0, 1, 1, 64'h6, 64'hFFFF_FFFF_FFFF_1234, 0, 0, 0, 0, 0, 8'hC0, 64'h1234_0000_0000_0000, 0);
    add(0, 0, 3, 64'h18, 0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 64'h18, 0, 0, 64'hFEDC_BA98_7654_3210);
    add(1, 0, 3, 64'h8, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(1, 1, 3, 64'h8, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(1, 0, 6, 64'h4, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(1, 0, 3, 64'h1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(1, 1, 2, 64'h4, 64'h1111_2222_DEAD_BEEF, 0, 1, 0, 0, 64'h4, 8'h0F, 64'hDEAD_BEEF, 0);
    add(1, 0, 1, 64'h2, 0, 64'h7FFF_0000, 0, 0, 0, 0, 0, 0, 64'h7FFF);
    add(1, 0, 0, 64'h1, 0, 64'hF000, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFF0);
    add(1, 0, 2, 64'h6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 64'h7, 64'h5A, 0, 0, 0, 0, 64'h4, 8'h08, 64'h5A00_0000, 0);
    add(1, 0, 5, 64'h2, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h8000);

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst req_ready", obs[s].req_ready, 1);
      chk("rst resp_valid", obs[s].resp_valid, 0);
      chk("rst ram_req", obs[s].ram_req, 0);
      chk("rst ram_we", obs[s].ram_we, 0);
      chk("rst ram_addr", obs[s].addr, 0);
      chk("rst ram_w_strb", obs[s].strb, 0);
      chk("rst ram_w_data", obs[s].wdata, 0);
      chk("rst resp_rdata", obs[s].rdata, 0);
      chk("rst resp_err", obs[s].err, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vq[i]) do_access(vq[i], vq[i].e);

    // Timeout: no ack for four REQ cycles, then a late ack must be ignored.
    st = 0; ty = 3'd2; addr = 64'h8; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("tout ram_req c1", obs[0].ram_req, 1);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("tout ram_req held", obs[0].ram_req, 1);
    end
    @(posedge clk); #1;
    chk("tout ram_req drop", obs[0].ram_req, 0);
    chk("tout resp_valid", obs[0].resp_valid, 1);
    chk("tout resp_err", obs[0].err, 3);
    chk("tout resp_rdata", obs[0].rdata, 0);
    ack[0] = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    chk("late ack resp_err", obs[0].err, 3);
    chk("late ack resp_rdata", obs[0].rdata, 0);
    ack[0] = 1'b0; rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0; ack[0] = 1'b1;
    chk("tout done valid", obs[0].resp_valid, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("late ack no resp", obs[0].resp_valid, 0);
      chk("late ack no ram_req", obs[0].ram_req, 0);
    end
    ack[0] = 1'b0;

    // Reset while in REQ aborts the access with no response.
    st = 1; ty = 3'd3; addr = 64'h40; wdata = 64'h55; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("abort ram_req before", obs[0].ram_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort ram_req", obs[0].ram_req, 0);
    chk("abort resp_valid", obs[0].resp_valid, 0);
    chk("abort req_ready", obs[0].req_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no resp", obs[0].resp_valid, 0);
    end

    // Randomized accesses against the byte-wise model.
    for (int n = 0; n < 200; n++) begin
      v.is32 = ($urandom_range(0, 1) == 1);
      v.st   = 1'($urandom_range(0, 1));
      v.ty   = 3'($urandom_range(0, 7));
      v.addr = {32'b0, $urandom};
      if ($urandom_range(0, 1) == 1) v.addr[2:0] = 3'b000;
      v.wdata   = {$urandom, $urandom};
      v.rdata   = {$urandom, $urandom};
      v.ack_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 2);
      do_access(v, model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/lsu_access_unit.md
Name: lsu_access_unit

Overview:
- Parametrised, handshaked load/store unit placed between the execute/memory pipeline register and the data RAM port.
- Successor to the combinational memory stage. Adds the following:
  - XLEN generalisation (32/64).
  - Per-byte strobes.
  - A registered multi-cycle memory request/acknowledge protocol.
  - Misalignment and illegal-width traps.
  - A bus timeout counter.
- Accepts one access at a time, aligns data into/out of the RAM lane, sign/zero-extends loads, and returns one response per request.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TIMEOUT_CYC, 255, cycles in REQ without ram_ack before a timeout error response; must be ≥ 1.
- ALLOW_MISALIGN, 0, reserved; must be 0 (misaligned accesses always trap).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  unit can accept an access.
- req_store  in  1  1 = store, 0 = load.
- req_type  in  3  store: 0 sb, 1 sh, 2 sw, 3 sd. Load: 0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  0 ok, 1 misaligned, 2 illegal type, 3 timeout.
- ram_req  out  1  memory request.
- ram_we  out  1  write enable.
- ram_addr  out  XLEN  lane-aligned address (low log2(XLEN/8) bits zero).
- ram_w_strb  out  XLEN/8  byte write strobes.
- ram_w_data  out  XLEN  lane-positioned store data.
- ram_ack  in  1  memory accepted/completed; read data valid the same cycle.
- ram_r_data  in  XLEN  read lane.

Behaviour:
- All outputs are registered. On rst:
  - State becomes IDLE.
  - req_ready becomes 1.
  - resp_valid, ram_req, ram_we, ram_w_strb, ram_addr, ram_w_data, resp_rdata and resp_err become 0.
- FSM states and transitions:
  - IDLE → REQ on req_valid & req_ready when the access is legal. Capture req_* at this edge.
  - IDLE → RESP with an error when the access is illegal. No RAM access is made.
  - REQ: ram_req = 1. Address, data, strobe and we are held stable until ram_ack. On ram_ack: ram_req drops next cycle, load data is latched, go to RESP.
  - RESP: resp_valid = 1 and resp_* held until resp_ready, then go to IDLE.
- req_ready = 1 only in IDLE.
- Minimum latency:
  - Accept at edge T. ram_req is high in cycle T+1.
  - Ack in T+1 gives resp_valid in T+2.
  - Error path gives resp_valid in T+1.
- Illegal type (resp_err = 2) has priority over misalignment and covers:
  - store type > 3;
  - load type 7;
  - for XLEN = 32, sd, ld and lwu.
- Misalignment (resp_err = 1): size 2 or 4 or 8 bytes with addr mod size ≠ 0.
- Store lane placement:
  - Byte offset o = addr[log2(XLEN/8)-1:0].
  - ram_w_data = wdata[size*8-1:0] << 8*o.
  - ram_w_strb = ((1 << size) - 1) << o.
  - Unused bytes are 0.
- Loads: ram_we = 0 and ram_w_strb = 0. Result = ram_r_data >> 8*o, truncated to size, then sign-extended (types 0–2) or zero-extended (4–6). ld and sd (XLEN = 64) pass the full width.
- Timeout:
  - Counter is cleared on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC: drop ram_req and go to RESP with resp_err = 3.
  - An ram_ack arriving after abandonment is ignored.
  - Ack in the same cycle as the counter reaching the limit counts as success.
- Response with resp_ready already high: it completes in one cycle. A new request is accepted no earlier than the following cycle (the unit is in IDLE).
- rst in any state aborts the access. ram_req is 0 after that edge and no response is produced.

Test Plan:
- XLEN=64, store sb, addr 0x8000_0005, wdata 0xAB, ack after 3 cycles → ram_addr 0x8000_0000, strb 0x20, ram_w_data 0x0000_AB00_0000_0000, ram_req held 3 cycles, resp_err 0.
- XLEN=64, lh at addr 0x...6, ram_r_data 0x8001_0000_0000_0000 → resp_rdata 0xFFFF_FFFF_FFFF_8001. Same access with lhu → 0x0000_0000_0000_8001.
- lw at addr 0x...2 → resp_valid the cycle after accept, resp_err 1, ram_req never asserted. Load type 7 → resp_err 2.
- XLEN=32 instance, ld or sd request → resp_err 2. sw at addr 0x4 → strb 0xF, ram_addr 0x4.
- TIMEOUT_CYC=4, ram_ack held 0 → after 4 REQ cycles ram_req drops, resp_err 3. A subsequent late ram_ack → no second response.
- Backpressure: resp_ready low for 5 cycles → resp_* stable and req_ready 0 throughout. Then assert rst during REQ → next cycle ram_req 0, resp_valid 0, req_ready 1.
